// File: rtl/ram_readback_fsm.sv
// ram_readback_fsm
//
// Read-side companion to the RAM write FSM. After the writer fills the shared
// single-port RAM, this block reads every address in ascending order. Each
// word is shown on the LEDs for HOLD_CYCLES enabled cycles and compared with
// the writer's pattern. Any mismatching word sets a sticky red LED and
// increments the per-sweep error count.
//
// RAM read protocol: o_rd_en is a one-cycle strobe. It is asserted only in
// ISSUE, with o_rd_addr valid in that same cycle. i_rd_data is valid exactly
// one cycle later, in WAIT. Only one read is ever outstanding, so no
// back-pressure exists on either side.
//
// Ports:
//   clock        in   1         system clock, rising edge
//   i_reset      in   1         asynchronous active-high reset
//   i_start      in   1         starts a sweep; sampled in IDLE and DONE only
//   i_enable     in   1         display-advance enable; low freezes SHOW
//   o_rd_en      out  1         RAM read strobe
//   o_rd_addr    out  ADDR_W    RAM read address (meaningful with o_rd_en)
//   i_rd_data    in   DATA_W    RAM read data, one cycle after o_rd_en
//   o_leds       out  DATA_W    last word read
//   o_led_r      out  1         sticky mismatch flag for the current sweep
//   o_err_count  out  ADDR_W+1  mismatching words in the current sweep
//   o_busy       out  1         high in ISSUE, WAIT and SHOW
//   o_done       out  1         high in DONE
//   o_state_dbg  out  3         current FSM state encoding
module ram_readback_fsm #(
   parameter int unsigned        ADDR_W      = 4,
   parameter int unsigned        DATA_W      = 4,
   parameter logic [DATA_W-1:0]  PATTERN     = DATA_W'(4'hA),
   parameter int unsigned        HOLD_CYCLES = 4
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_enable,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_leds,
   output logic              o_led_r,
   output logic [ADDR_W:0]   o_err_count,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_SHOW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // The hold counter only needs to reach HOLD_CYCLES-1.
   localparam int unsigned       HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
   localparam logic [HC_W-1:0]   HOLD_ONE  = HC_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W + 1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [HC_W-1:0]     hold_q,  hold_d;
   logic [DATA_W-1:0]   leds_q,  leds_d;
   logic                led_r_q, led_r_d;
   logic [ADDR_W:0]     err_q,   err_d;
   logic [DATA_W-1:0]   expected_w;

   // The address is zero-extended or truncated to the word width before the
   // pattern is applied, matching what the writer stores.
   assign expected_w = DATA_W'(addr_q) ^ PATTERN;

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         hold_q  <= '0;
         leds_q  <= '0;
         led_r_q <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hold_q  <= hold_d;
         leds_q  <= leds_d;
         led_r_q <= led_r_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      leds_d  = leds_q;
      led_r_d = led_r_q;
      err_d   = err_q;

      case (state_q)
         // DONE restarts exactly like IDLE, including clearing the error state.
         // The LEDs keep showing the previous word until the first new read lands.
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_d = S_ISSUE;
               addr_d  = '0;
               led_r_d = 1'b0;
               err_d   = '0;
            end
         end

         // ISSUE and WAIT ignore i_enable so that a read is never abandoned.
         S_ISSUE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            leds_d = i_rd_data;
            hold_d = '0;
            if (i_rd_data != expected_w) begin
               err_d   = err_q + ERR_ONE;
               led_r_d = 1'b1;
            end
            state_d = S_SHOW;
         end

         S_SHOW: begin
            if (i_enable) begin
               if (hold_q == HOLD_LAST) begin
                  if (addr_q == ADDR_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d  = addr_q + ADDR_ONE;
                     state_d = S_ISSUE;
                  end
               end else begin
                  hold_d = hold_q + HOLD_ONE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_rd_en     = (state_q == S_ISSUE);
   assign o_rd_addr   = addr_q;
   assign o_leds      = leds_q;
   assign o_led_r     = led_r_q;
   assign o_err_count = err_q;
   assign o_busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SHOW);
   assign o_done      = (state_q == S_DONE);
   assign o_state_dbg = state_q;

endmodule

// File: tb/tb_ram_readback_fsm.sv
// Bench for ram_readback_fsm. A 1-cycle-latency RAM model feeds the DUT. Each
// sweep is observed cycle by cycle, and the results are compared with a
// word-level reference computed from the RAM contents.
module tb_ram_readback_fsm;

   localparam int         AW   = 4;
   localparam int         DW   = 4;
   localparam int         HOLD = 4;
   localparam int         NW   = 1 << AW;
   localparam logic [3:0] PAT  = 4'hA;

   logic          clock;
   logic          i_reset;
   logic          i_start;
   logic          i_enable;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] o_leds;
   logic          o_led_r;
   logic [AW:0]   o_err_count;
   logic          o_busy;
   logic          o_done;
   logic [2:0]    o_state_dbg;

   ram_readback_fsm #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .PATTERN     (PAT),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_enable    (i_enable),
      .o_rd_en     (o_rd_en),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (rd_data),
      .o_leds      (o_leds),
      .o_led_r     (o_led_r),
      .o_err_count (o_err_count),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_state_dbg (o_state_dbg)
   );

   // ---------------- clock / RAM model ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [DW-1:0] mem [NW];

   always @(posedge clock) begin
      if (o_rd_en) rd_data <= mem[o_rd_addr];
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   // reference model results
   logic [DW-1:0] exp_leds[$];
   logic          exp_ledr[$];
   logic [AW:0]   exp_err[$];
   int            exp_done;

   // observed per-sweep results
   int            obs_rd_addr[$];
   logic [DW-1:0] obs_leds[$];
   logic          obs_ledr[$];
   logic [AW:0]   obs_err[$];
   int            obs_done_cyc;
   int            obs_busy_bad;
   int            obs_pause_rd;
   int            obs_pause_chg;
   bit            obs_pause_hit;
   logic          obs_ledr0;
   logic [AW:0]   obs_err0;

   // Each word takes one read plus HOLD_CYCLES enabled display cycles and the
   // read-latency cycle. The error count is a running count of words that
   // differ from address^PATTERN.
   task automatic build_model(input int pause_len);
      int errs;
      logic [DW-1:0] av;
      exp_leds.delete(); exp_ledr.delete(); exp_err.delete();
      errs = 0;
      for (int a = 0; a < NW; a++) begin
         av = a[DW-1:0];
         exp_leds.push_back(mem[a]);
         if (mem[a] !== (av ^ PAT)) errs++;
         exp_err.push_back((AW+1)'(errs));
         exp_ledr.push_back(errs > 0);
      end
      exp_done = NW * (HOLD + 2) + pause_len;
   endtask

   task automatic fill_clean();
      logic [DW-1:0] av;
      for (int a = 0; a < NW; a++) begin
         av = a[DW-1:0];
         mem[a] = av ^ PAT;
      end
   endtask

   // ---------------- driver / monitor ----------------
   // Pulses i_start. The first sampled cycle (cyc 0) is the first ISSUE cycle.
   // The task records each read and the LED state on the first SHOW cycle of
   // each word. Optionally it drops i_enable in the second SHOW cycle of
   // pause_addr for pause_len cycles. It also pulses i_start at busy_cyc,
   // while the sweep is busy.
   task automatic run_sweep(input int pause_addr, input int pause_len, input int busy_cyc);
      int cyc, last_rd, cur_addr, paused_left;
      logic [DW-1:0] frozen;
      obs_rd_addr.delete(); obs_leds.delete(); obs_ledr.delete(); obs_err.delete();
      obs_done_cyc = -1; obs_busy_bad = 0; obs_pause_rd = 0; obs_pause_chg = 0;
      obs_pause_hit = 0;
      last_rd = -10; cur_addr = -1; paused_left = 0; frozen = '0;
      @(negedge clock); i_start = 1'b1;
      @(negedge clock); i_start = 1'b0;
      obs_ledr0 = o_led_r;
      obs_err0  = o_err_count;
      cyc = 0;
      while (cyc < 400) begin
         if (o_done === 1'b1) begin
            obs_done_cyc = cyc;
            break;
         end
         if (o_busy !== 1'b1) obs_busy_bad++;
         if (o_rd_en === 1'b1) begin
            obs_rd_addr.push_back(int'(o_rd_addr));
            last_rd = cyc;
            cur_addr = int'(o_rd_addr);
         end
         if (cyc == last_rd + 2) begin
            obs_leds.push_back(o_leds);
            obs_ledr.push_back(o_led_r);
            obs_err.push_back(o_err_count);
            frozen = o_leds;
         end
         if (paused_left > 0) begin
            if (o_rd_en !== 1'b0) obs_pause_rd++;
            if (o_leds !== frozen) obs_pause_chg++;
            paused_left--;
            if (paused_left == 0) i_enable = 1'b1;
         end else if (pause_len > 0 && !obs_pause_hit && cur_addr == pause_addr
                      && cyc == last_rd + 3) begin
            i_enable = 1'b0;
            paused_left = pause_len;
            obs_pause_hit = 1;
         end
         i_start = (cyc == busy_cyc);
         @(negedge clock);
         cyc++;
      end
      i_start  = 1'b0;
      i_enable = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      i_reset = 1'b1; i_start = 1'b0; i_enable = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++;
      if (o_rd_en !== 1'b0 || o_rd_addr !== '0 || o_leds !== '0 || o_led_r !== 1'b0
          || o_err_count !== '0 || o_busy !== 1'b0 || o_done !== 1'b0)
         $display("FAIL reset_outputs rd_en=%b addr=%h leds=%h led_r=%b err=%0d busy=%b done=%b required all 0",
                  o_rd_en, o_rd_addr, o_leds, o_led_r, o_err_count, o_busy, o_done);
      else n_pass++;
      i_reset = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (o_rd_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0)
         $display("FAIL reset_idle_no_start rd_en=%b busy=%b done=%b required 0 0 0",
                  o_rd_en, o_busy, o_done);
      else n_pass++;
   endtask

   task automatic test_clean_sweep();
      fill_clean();
      build_model(0);
      run_sweep(-1, 0, 40);
      n_checks++;
      if (obs_rd_addr.size() != NW || obs_leds.size() != NW)
         $display("FAIL clean_count reads=%0d shows=%0d required %0d", obs_rd_addr.size(), obs_leds.size(), NW);
      else n_pass++;
      for (int a = 0; a < NW; a++) begin
         n_checks++;
         if (a >= obs_leds.size() || a >= obs_rd_addr.size())
            $display("FAIL clean_word%0d missing", a);
         else if (obs_rd_addr[a] != a || obs_leds[a] !== exp_leds[a] || obs_ledr[a] !== exp_ledr[a] || obs_err[a] !== exp_err[a])
            $display("FAIL clean_word%0d addr=%0d leds=%h led_r=%b err=%0d required addr=%0d leds=%h led_r=%b err=%0d",
                     a, obs_rd_addr[a], obs_leds[a], obs_ledr[a], obs_err[a], a, exp_leds[a], exp_ledr[a], exp_err[a]);
         else n_pass++;
      end
      n_checks++;
      if (obs_done_cyc != exp_done) $display("FAIL clean_done_cycle got=%0d required=%0d", obs_done_cyc, exp_done);
      else n_pass++;
      n_checks++;
      if (obs_busy_bad != 0) $display("FAIL clean_busy not-busy cycles=%0d required 0", obs_busy_bad);
      else n_pass++;
      n_checks++;
      if (o_leds !== exp_leds[NW-1] || o_led_r !== 1'b0 || o_err_count !== '0 || o_busy !== 1'b0)
         $display("FAIL clean_done_hold leds=%h led_r=%b err=%0d busy=%b required leds=%h 0 0 0",
                  o_leds, o_led_r, o_err_count, o_busy, exp_leds[NW-1]);
      else n_pass++;
   endtask

   task automatic test_single_fault();
      fill_clean();
      mem[7] = 4'h0;
      build_model(0);
      run_sweep(-1, 0, -1);
      for (int a = 0; a < NW; a++) begin
         n_checks++;
         if (a >= obs_leds.size() || a >= obs_rd_addr.size())
            $display("FAIL fault_word%0d missing", a);
         else if (obs_rd_addr[a] != a || obs_leds[a] !== exp_leds[a] || obs_ledr[a] !== exp_ledr[a] || obs_err[a] !== exp_err[a])
            $display("FAIL fault_word%0d addr=%0d leds=%h led_r=%b err=%0d required addr=%0d leds=%h led_r=%b err=%0d",
                     a, obs_rd_addr[a], obs_leds[a], obs_ledr[a], obs_err[a], a, exp_leds[a], exp_ledr[a], exp_err[a]);
         else n_pass++;
      end
      n_checks++;
      if (obs_done_cyc != exp_done) $display("FAIL fault_done_cycle got=%0d required=%0d", obs_done_cyc, exp_done);
      else n_pass++;
      repeat (3) @(negedge clock);
      n_checks++;
      if (o_done !== 1'b1 || o_led_r !== 1'b1 || o_err_count !== 5'd1)
         $display("FAIL fault_done_hold done=%b led_r=%b err=%0d required 1 1 1", o_done, o_led_r, o_err_count);
      else n_pass++;
   endtask

   task automatic test_restart_from_done();
      fill_clean();
      build_model(0);
      run_sweep(-1, 0, 20);
      n_checks++;
      if (obs_ledr0 !== 1'b0 || obs_err0 !== '0)
         $display("FAIL restart_clear led_r=%b err=%0d at first ISSUE required 0 0", obs_ledr0, obs_err0);
      else n_pass++;
      n_checks++;
      if (obs_rd_addr.size() != NW) $display("FAIL restart_count reads=%0d required %0d", obs_rd_addr.size(), NW);
      else n_pass++;
      n_checks++;
      if (obs_done_cyc != exp_done || o_err_count !== '0 || o_led_r !== 1'b0)
         $display("FAIL restart_result done_cyc=%0d err=%0d led_r=%b required %0d 0 0",
                  obs_done_cyc, o_err_count, o_led_r, exp_done);
      else n_pass++;
   endtask

   task automatic test_pause();
      fill_clean();
      build_model(20);
      run_sweep(3, 20, -1);
      n_checks++;
      if (!obs_pause_hit || obs_pause_rd != 0 || obs_pause_chg != 0)
         $display("FAIL pause_frozen hit=%0d reads=%0d led_changes=%0d required 1 0 0",
                  obs_pause_hit, obs_pause_rd, obs_pause_chg);
      else n_pass++;
      n_checks++;
      if (obs_leds.size() < 4 || obs_leds[3] !== 4'h9)
         $display("FAIL pause_word3 leds=%h required 9", (obs_leds.size() < 4) ? 4'hx : obs_leds[3]);
      else n_pass++;
      n_checks++;
      if (obs_done_cyc != exp_done) $display("FAIL pause_done_cycle got=%0d required=%0d", obs_done_cyc, exp_done);
      else n_pass++;
      n_checks++;
      if (obs_rd_addr.size() != NW) $display("FAIL pause_count reads=%0d required %0d", obs_rd_addr.size(), NW);
      else n_pass++;
   endtask

   task automatic test_reset_mid_sweep();
      int rd_seen;
      int waited;
      fill_clean();
      @(negedge clock); i_start = 1'b1;
      @(negedge clock); i_start = 1'b0;
      waited = 0;
      while (!(o_rd_en === 1'b1 && o_rd_addr === 4'd5) && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      n_checks++;
      if (waited >= 100) $display("FAIL midreset_reach_addr5 timeout after %0d cycles", waited);
      else n_pass++;
      repeat (2) @(negedge clock);
      #2 i_reset = 1'b1;
      #1;
      n_checks++;
      if (o_rd_en !== 1'b0 || o_rd_addr !== '0 || o_leds !== '0 || o_led_r !== 1'b0
          || o_err_count !== '0 || o_busy !== 1'b0 || o_done !== 1'b0)
         $display("FAIL midreset_async rd_en=%b addr=%h leds=%h led_r=%b err=%0d busy=%b done=%b required all 0",
                  o_rd_en, o_rd_addr, o_leds, o_led_r, o_err_count, o_busy, o_done);
      else n_pass++;
      @(negedge clock); i_reset = 1'b0;
      rd_seen = 0;
      repeat (10) begin
         @(negedge clock);
         if (o_rd_en !== 1'b0 || o_busy !== 1'b0) rd_seen++;
      end
      n_checks++;
      if (rd_seen != 0) $display("FAIL midreset_stays_idle active cycles=%0d required 0", rd_seen);
      else n_pass++;
      build_model(0);
      run_sweep(-1, 0, -1);
      n_checks++;
      if (obs_rd_addr.size() != NW || obs_done_cyc != exp_done || o_err_count !== '0 || o_led_r !== 1'b0)
         $display("FAIL midreset_resweep reads=%0d done_cyc=%0d err=%0d led_r=%b required %0d %0d 0 0",
                  obs_rd_addr.size(), obs_done_cyc, o_err_count, o_led_r, NW, exp_done);
      else n_pass++;
   endtask

   task automatic test_random();
      int pa, pl, bc;
      logic [DW-1:0] av;
      for (int it = 0; it < 4; it++) begin
         for (int a = 0; a < NW; a++) begin
            av = a[DW-1:0];
            if ($urandom_range(0, 1) == 1) mem[a] = av ^ PAT;
            else mem[a] = DW'($urandom_range(0, 15));
         end
         pa = $urandom_range(0, NW - 1);
         pl = $urandom_range(1, 25);
         bc = $urandom_range(3, 90);
         build_model(pl);
         run_sweep(pa, pl, bc);
         n_checks++;
         if (obs_rd_addr.size() != NW || obs_leds.size() != NW)
            $display("FAIL rand%0d_count reads=%0d shows=%0d required %0d", it, obs_rd_addr.size(), obs_leds.size(), NW);
         else n_pass++;
         for (int a = 0; a < NW; a++) begin
            n_checks++;
            if (a >= obs_leds.size() || a >= obs_rd_addr.size())
               $display("FAIL rand%0d_word%0d missing", it, a);
            else if (obs_rd_addr[a] != a || obs_leds[a] !== exp_leds[a] || obs_ledr[a] !== exp_ledr[a] || obs_err[a] !== exp_err[a])
               $display("FAIL rand%0d_word%0d addr=%0d leds=%h led_r=%b err=%0d required addr=%0d leds=%h led_r=%b err=%0d",
                        it, a, obs_rd_addr[a], obs_leds[a], obs_ledr[a], obs_err[a], a, exp_leds[a], exp_ledr[a], exp_err[a]);
            else n_pass++;
         end
         n_checks++;
         if (obs_done_cyc != exp_done || obs_pause_rd != 0 || obs_pause_chg != 0)
            $display("FAIL rand%0d_timing done_cyc=%0d pause_reads=%0d pause_changes=%0d required %0d 0 0",
                     it, obs_done_cyc, obs_pause_rd, obs_pause_chg, exp_done);
         else n_pass++;
         n_checks++;
         if (o_err_count !== exp_err[NW-1] || o_led_r !== exp_ledr[NW-1] || o_leds !== exp_leds[NW-1])
            $display("FAIL rand%0d_final err=%0d led_r=%b leds=%h required %0d %b %h",
                     it, o_err_count, o_led_r, o_leds, exp_err[NW-1], exp_ledr[NW-1], exp_leds[NW-1]);
         else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      i_reset  = 1'b1;
      i_start  = 1'b0;
      i_enable = 1'b1;
      test_reset();
      test_clean_sweep();
      test_single_fault();
      test_restart_from_done();
      test_pause();
      test_reset_mid_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_readback_fsm.md
# ram_readback_fsm

Read-side companion to the RAM write FSM: after the writer has filled the shared single-port RAM, this block sweeps every address in order and holds each word on the board LEDs for a programmable time. It checks each word against the pattern the writer stores and raises a sticky red LED on any mismatch. It sits between the RAM read port and the LED outputs, and is started by the writer's completion strobe.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; the sweep covers 2^ADDR_W words.
- DATA_W, 4, RAM word width and LED count.
- PATTERN, 4'hA, expected word at address a is a[DATA_W-1:0] ^ PATTERN (zero-extended address).
- HOLD_CYCLES, 4, number of enabled cycles each word is displayed; must be ≥1.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  level, sampled in IDLE and DONE only; starts a sweep.
- i_enable  in  1  display-advance enable; low freezes the hold counter.
- o_rd_en  out  1  RAM read strobe, one cycle per word.
- o_rd_addr  out  ADDR_W  RAM read address.
- i_rd_data  in  DATA_W  RAM read data, valid the cycle after o_rd_en.
- o_leds  out  DATA_W  last word read.
- o_led_r  out  1  sticky mismatch flag.
- o_err_count  out  ADDR_W+1  number of mismatching words in the current sweep.
- o_busy  out  1  high in ISSUE, WAIT and SHOW.
- o_done  out  1  high in DONE.

## Operation
- Reset (asynchronous assert, released synchronously by the clock): state IDLE; all outputs 0; address, hold counter and error count are 0.
- IDLE: if i_start=1, go to ISSUE with addr=0, clear o_led_r and o_err_count.
- ISSUE: o_rd_en=1 and o_rd_addr=addr for exactly this cycle; next state is WAIT unconditionally.
- WAIT: i_rd_data is valid. At the clock edge:
  - o_leds <= i_rd_data.
  - If i_rd_data != expected(addr): o_err_count increments and o_led_r <= 1.
  - Hold counter <= 0.
  - Next state is SHOW.
- SHOW:
  - The hold counter increments only when i_enable=1.
  - When the counter reaches HOLD_CYCLES-1 with i_enable=1:
    - if addr == 2^ADDR_W-1, go to DONE;
    - otherwise addr increments and the next state is ISSUE.
  - With i_enable=0 the block stays in SHOW indefinitely and o_leds is stable.
- DONE: o_done=1. o_leds keeps the last word; o_led_r and o_err_count keep their values. i_start=1 restarts exactly as from IDLE, including clearing the error state.
- i_enable affects only SHOW. ISSUE and WAIT always complete so that the RAM read is never abandoned.
- i_start is ignored while o_busy=1.
- o_err_count cannot overflow: its maximum is 2^ADDR_W, which fits in ADDR_W+1 bits.
- o_rd_addr holds its last value outside ISSUE; it is only meaningful when o_rd_en=1.

## Timing
- i_start sampled high at edge k. ISSUE is at k+1, WAIT at k+2, and o_leds updates at edge k+3, the first SHOW cycle.
- With i_enable held high, each word takes HOLD_CYCLES+2 cycles. A full sweep takes 2^ADDR_W·(HOLD_CYCLES+2) cycles from the first ISSUE to the first DONE cycle; with the defaults this is 96.
- o_led_r and o_err_count update at the same edge as o_leds for the offending word.
- RAM read latency is fixed at 1 cycle. Only one read is outstanding at a time.
- Reset asserted mid-sweep forces IDLE and zeros every output immediately, without waiting for a clock edge. No further o_rd_en is issued until a new i_start.

## Test plan
- Clean sweep: RAM model preloaded with a^4'hA, i_enable=1, pulse i_start. Required: 16 o_rd_en pulses at addresses 0..15, o_leds sequence A,B,8,9,…,5, o_led_r=0, o_err_count=0, o_done at cycle 96 after the first ISSUE.
- Single fault: corrupt address 7 to 4'h0. Required: o_led_r rises at the edge o_leds shows 0, stays high through DONE, o_err_count=1.
- Pause: drop i_enable for 20 cycles mid-SHOW at address 3. Required: o_leds frozen at 9, no o_rd_en, and the sweep ends 20 cycles later than in the clean sweep.
- Reset mid-sweep: assert i_reset asynchronously while at address 5. Required: all outputs 0 within the same cycle, state IDLE, and a clean sweep after re-start.
- Restart from DONE: after a faulty sweep, fix the RAM and assert i_start in DONE. Required: o_led_r and o_err_count are cleared at the IDLE-equivalent transition and the second sweep reports 0 errors. i_start pulsed while busy has no effect.
